// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage between a 32-word synchronous-read instruction RAM
// and the decoder. Owns the program counter, keeps the RAM permanently in
// read mode, hides the RAM's one-cycle registered read latency and hands
// words to decode over a valid/ready handshake. A one-word skid register
// keeps the presented word stable through decode stalls, and a later stage
// can redirect fetch with a single-cycle branch pulse.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   en             run enable; 0 stops new fetches (a presented word drains)
//   mem_address    RAM address, always the fetch pc register
//   mem_we         RAM mode select, tied to 1 (read)
//   mem_rdata      RAM read data = mem[address sampled at the previous edge]
//   instr          word to decode (skid copy while stalled, else RAM data)
//   instr_pc       address of instr
//   instr_valid    instr / instr_pc are valid
//   dec_ready      decoder accepts; transfer = instr_valid && dec_ready
//   branch_valid   single-cycle redirect request
//   branch_target  redirect address (out-of-range targets restart at 0)
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int data_length = 32,
  parameter int mem_length  = 32,
  parameter int RESET_PC    = 0,
  localparam int A = (mem_length > 1) ? $clog2(mem_length) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [A-1:0]           mem_address,
  output logic                   mem_we,
  input  logic [data_length-1:0] mem_rdata,
  output logic [data_length-1:0] instr,
  output logic [A-1:0]           instr_pc,
  output logic                   instr_valid,
  input  logic                   dec_ready,
  input  logic                   branch_valid,
  input  logic [A-1:0]           branch_target
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [A-1:0]           fetch_pc_reg,   fetch_pc_next;
  logic [A-1:0]           rd_pc_reg,      rd_pc_next;
  logic                   rd_valid_reg,   rd_valid_next;
  logic                   skid_valid_reg, skid_valid_next;
  logic [data_length-1:0] skid_instr_reg, skid_instr_next;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  logic         advance;
  logic         stall;
  logic         drain;
  logic         target_in_range;
  logic [A-1:0] fetch_pc_inc;

  // A new fetch can be issued whenever the output slot is empty or is being
  // emptied this cycle by the decoder.
  assign advance = en && (!rd_valid_reg || dec_ready);
  assign stall   = rd_valid_reg && !dec_ready;
  assign drain   = rd_valid_reg && dec_ready && !en;

  // Comparison done at 32 bits so that a non-power-of-two memory can still
  // detect targets past the last word; for power-of-two sizes it folds away.
  assign target_in_range = (32'(branch_target) < mem_length);

  // Sequential fetch wraps from the last word back to word 0.
  assign fetch_pc_inc = (32'(fetch_pc_reg) == (mem_length - 1)) ? '0
                                                                : fetch_pc_reg + A'(1);

  // -------------------------------------------------------------------------
  // Next-state logic, first matching condition wins:
  //   branch > advance > stall > drain > hold
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_pc_next   = fetch_pc_reg;
    rd_pc_next      = rd_pc_reg;
    rd_valid_next   = rd_valid_reg;
    skid_valid_next = skid_valid_reg;
    skid_instr_next = skid_instr_reg;

    if (branch_valid) begin
      // Redirect throws away whatever is presented or parked in the skid.
      // A transfer happening in this same cycle has already been taken by
      // the decoder, so nothing is lost.
      fetch_pc_next   = target_in_range ? branch_target : '0;
      rd_valid_next   = 1'b0;
      skid_valid_next = 1'b0;
    end else if (advance) begin
      // The RAM samples fetch_pc at this edge, so next cycle mem_rdata
      // holds exactly the word at rd_pc.
      rd_pc_next      = fetch_pc_reg;
      rd_valid_next   = 1'b1;
      skid_valid_next = 1'b0;
      fetch_pc_next   = fetch_pc_inc;
    end else if (stall) begin
      // fetch_pc already points one word ahead, and the RAM keeps reading
      // it every stalled cycle, so mem_rdata changes after the first stall
      // edge. The presented word must be copied at that first edge.
      if (!skid_valid_reg) begin
        skid_instr_next = mem_rdata;
        skid_valid_next = 1'b1;
      end
    end else if (drain) begin
      // Fetch disabled and the last word just went out.
      rd_valid_next   = 1'b0;
      skid_valid_next = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg   <= A'(RESET_PC);
      rd_pc_reg      <= '0;
      rd_valid_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_instr_reg <= '0;
    end else begin
      fetch_pc_reg   <= fetch_pc_next;
      rd_pc_reg      <= rd_pc_next;
      rd_valid_reg   <= rd_valid_next;
      skid_valid_reg <= skid_valid_next;
      skid_instr_reg <= skid_instr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_address = fetch_pc_reg;
  assign mem_we      = 1'b1;
  assign instr_pc    = rd_pc_reg;
  assign instr_valid = rd_valid_reg;

  // While stalled the skid copy is the authoritative word; once released the
  // RAM output already carries the word at rd_pc, so there is no bubble.
  generate
    for (genvar gi = 0; gi < data_length; gi++) begin : g_instr_mux
      assign instr[gi] = skid_valid_reg ? skid_instr_reg[gi] : mem_rdata[gi];
    end
  endgenerate

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Drives instr_fetch against a behavioural 32-word synchronous-read RAM
// preloaded with mem[k] = 0x100 + k. Stimulus pushes the transfers it
// expects onto a scoreboard queue; an independent monitor pops and compares
// on every observed transfer. Cycle-specific checks (bubbles, stall holds,
// reset state) are made directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int DW = 32;
  localparam int ML = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [AW-1:0] mem_address;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          dec_ready;
  logic          branch_valid;
  logic [AW-1:0] branch_target;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] word;
  } exp_t;

  exp_t exp_q[$];

  logic [DW-1:0] mem [ML];

  always #5 clk = ~clk;

  instr_fetch #(
    .data_length (DW),
    .mem_length  (ML),
    .RESET_PC    (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .mem_address   (mem_address),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .dec_ready     (dec_ready),
    .branch_valid  (branch_valid),
    .branch_target (branch_target)
  );

  // Synchronous-read RAM model: data appears the cycle after the address.
  initial begin
    for (int k = 0; k < ML; k++) mem[k] = 32'h100 + k;
  end

  always @(posedge clk) mem_rdata <= mem[mem_address];

  // ---------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic push_exp(input int pc);
    exp_t e;
    e.pc   = AW'(pc);
    e.word = 32'h100 + pc;   // matches the RAM preload
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Monitor: compares every transfer against the scoreboard.
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL mem_we: got %b expected 1", mem_we);
    end
    if (instr_valid === 1'b1 && dec_ready === 1'b1) begin
      xfer_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got pc=%0d instr=0x%0h expected no transfer",
                 instr_pc, instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (instr_pc !== e.pc || instr !== e.word) begin
          errors++;
          $display("FAIL xfer: got pc=%0d instr=0x%0h expected pc=%0d instr=0x%0h",
                   instr_pc, instr, e.pc, e.word);
        end else begin
          $display("xfer pc=%0d instr=0x%0h", instr_pc, instr);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    int base;
    rst_n         = 1'b0;
    en            = 1'b1;
    dec_ready     = 1'b1;
    branch_valid  = 1'b0;
    branch_target = '0;

    // Reset state
    step();
    step();
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_addr",  32'(mem_address), 32'd0);
    chk("reset_pc",    32'(instr_pc),    32'd0);

    // Release: first advance edge, then valid
    rst_n = 1'b1;
    chk("release_valid_before_edge", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 32; k++) push_exp(k);
    push_exp(0);
    push_exp(1);
    step();
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_pc",    32'(instr_pc),    32'd0);
    chk("first_instr", instr,            32'h100);
    base = xfer_cnt;
    for (int k = 0; k < 34; k++) step();
    chk("wrap_no_bubble_count", 32'(xfer_cnt - base), 32'd34);

    // Advance to pc=5
    push_exp(2); push_exp(3); push_exp(4);
    for (int k = 0; k < 3; k++) step();
    chk("pre_stall_pc", 32'(instr_pc), 32'd5);

    // Stall three cycles at pc=5
    dec_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc",    32'(instr_pc),    32'd5);
      chk("stall_instr", instr,            32'h105);
      step();
    end
    dec_ready = 1'b1;
    chk("release_instr", instr, 32'h105);
    push_exp(5); push_exp(6); push_exp(7);
    base = xfer_cnt;
    for (int k = 0; k < 3; k++) step();
    chk("release_no_bubble_count", 32'(xfer_cnt - base), 32'd3);

    // Branch to 20 while pc=8 is accepted
    chk("pre_branch_pc", 32'(instr_pc), 32'd8);
    push_exp(8);
    branch_valid  = 1'b1;
    branch_target = 5'd20;
    step();
    branch_valid = 1'b0;
    chk("branch_bubble_valid", 32'(instr_valid), 32'd0);
    step();
    chk("branch_target_valid", 32'(instr_valid), 32'd1);
    chk("branch_target_pc",    32'(instr_pc),    32'd20);
    chk("branch_target_instr", instr,            32'h114);
    push_exp(20); push_exp(21);
    step();
    step();

    // Branch to 9, then stall there with a full skid and branch to 3
    push_exp(22);
    branch_valid  = 1'b1;
    branch_target = 5'd9;
    step();
    branch_valid = 1'b0;
    step();
    chk("skid_setup_pc", 32'(instr_pc), 32'd9);
    dec_ready = 1'b0;
    step();
    chk("skid_full_instr", instr, 32'h109);
    branch_valid  = 1'b1;
    branch_target = 5'd3;
    step();
    branch_valid = 1'b0;
    dec_ready    = 1'b1;
    chk("skid_flush_valid", 32'(instr_valid), 32'd0);
    step();
    chk("after_flush_pc",    32'(instr_pc), 32'd3);
    chk("after_flush_instr", instr,         32'h103);
    push_exp(3);
    step();

    // Mid-stream reset
    rst_n     = 1'b0;
    dec_ready = 1'b0;
    step();
    chk("midreset_valid", 32'(instr_valid), 32'd0);
    chk("midreset_addr",  32'(mem_address), 32'd0);
    chk("midreset_pc",    32'(instr_pc),    32'd0);
    rst_n     = 1'b1;
    dec_ready = 1'b1;
    step();
    chk("restart_pc",    32'(instr_pc), 32'd0);
    chk("restart_instr", instr,         32'h100);
    push_exp(0); push_exp(1);
    step();
    step();

    // en=0 with a word accepted: drains, fetch_pc holds
    en = 1'b0;
    push_exp(2);
    step();
    chk("drain_valid", 32'(instr_valid), 32'd0);
    chk("drain_addr",  32'(mem_address), 32'd3);
    base = xfer_cnt;
    step();
    chk("idle_valid", 32'(instr_valid), 32'd0);
    chk("idle_addr",  32'(mem_address), 32'd3);
    chk("idle_no_xfer", 32'(xfer_cnt - base), 32'd0);

    // en=0 while stalled: word held until accepted, then valid falls
    en = 1'b1;
    step();
    chk("reenable_pc", 32'(instr_pc), 32'd3);
    en        = 1'b0;
    dec_ready = 1'b0;
    step();
    step();
    chk("hold_valid", 32'(instr_valid), 32'd1);
    chk("hold_pc",    32'(instr_pc),    32'd3);
    chk("hold_instr", instr,            32'h103);
    chk("hold_addr",  32'(mem_address), 32'd4);
    dec_ready = 1'b1;
    push_exp(3);
    step();
    chk("final_drain_valid", 32'(instr_valid), 32'd0);
    chk("final_drain_addr",  32'(mem_address), 32'd4);
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
